useq_stack: RTL and testbench

USEQ_STACK -- requirements
Module: useq_stack

---
 rtl/useq_stack.sv | 171 +++++++++++++++++
 tb/tb_useq_stack.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/useq_stack.sv
// Tick-paced microsequencer with an external synchronous ROM, conditional branches and a bounded return stack.
// Latency: one FETCH cycle after each executed step; no backpressure, steps are paced only by the DIV tick.
module useq_stack #(
    parameter int AW  = 5,
    parameter int NC  = 6,
    parameter int OW  = 4,
    parameter int SD  = 4,
    parameter int DIV = 50000000,
    localparam int SW = $clog2(NC) + 1,
    localparam int IW = 3 + SW + AW + OW
) (
    input  logic          ck,
    input  logic          rst,
    input  logic [NC-1:0] cond,
    output logic [AW-1:0] rom_addr,
    input  logic [IW-1:0] rom_q,
    output logic [OW-1:0] ctl,
    output logic [AW-1:0] pc_o,
    output logic          tick_o,
    output logic          halted,
    output logic          err
);

    localparam int CW  = $clog2(DIV);
    localparam int SPW = $clog2(SD + 1);
    localparam int IXW = (SD > 1) ? $clog2(SD) : 1;
    localparam int XW  = SW - 1;
    localparam int PW  = 1 << XW;
    localparam int RW  = IW - OW;

    localparam logic [2:0] OP_CONT  = 3'b000;
    localparam logic [2:0] OP_JMP   = 3'b001;
    localparam logic [2:0] OP_JT    = 3'b010;
    localparam logic [2:0] OP_JF    = 3'b011;
    localparam logic [2:0] OP_CALL  = 3'b100;
    localparam logic [2:0] OP_RET   = 3'b101;
    localparam logic [2:0] OP_WAITC = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [1:0] {FETCH, READY, HALT, ERR} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [AW-1:0]  pc;
    logic [SPW-1:0] sp;
    logic [RW-1:0]  ir;
    logic [AW-1:0]  stk [SD];

    logic [2:0]     opc;
    logic [SW-1:0]  sel;
    logic [AW-1:0]  dir;
    logic [XW-1:0]  idx;
    logic [PW-1:0]  cond_pad;
    logic           x;
    logic [AW-1:0]  pc_inc;
    logic           full;
    logic           empty;
    logic           step;
    logic           push;

    // ir keeps only opc/sel/dir; the ctl field goes straight to the ctl register
    assign opc      = ir[RW-1 -: 3];
    assign sel      = ir[RW-4 -: SW];
    assign dir      = ir[AW-1:0];
    assign idx      = sel[XW-1:0];
    assign cond_pad = PW'(cond);

    // selects beyond the last condition input read as constant 0, inverted by the sel MSB
    always_comb begin
        x = sel[SW-1];
        if ({1'b0, idx} < SW'(NC))
            x = cond_pad[idx] ^ sel[SW-1];
    end

    assign pc_inc   = pc + AW'(1);
    assign full     = (sp == SPW'(SD));
    assign empty    = (sp == '0);
    assign tick_o   = (cnt == CW'(DIV - 1));
    assign step     = (state == READY) && tick_o;
    assign push     = step && (opc == OP_CALL) && !full;
    assign rom_addr = pc;
    assign pc_o     = pc;

    // stack contents need no reset: sp alone decides what is valid
    always_ff @(posedge ck) begin
        if (push)
            stk[IXW'(sp)] <= pc_inc;
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            cnt    <= '0;
            pc     <= '0;
            sp     <= '0;
            ir     <= '0;
            ctl    <= '0;
            halted <= 1'b0;
            err    <= 1'b0;
        end else begin
            cnt <= tick_o ? '0 : cnt + CW'(1);
            case (state)
                FETCH: begin
                    ir    <= rom_q[IW-1:OW];
                    ctl   <= rom_q[OW-1:0];
                    state <= READY;
                end
                READY: begin
                    if (tick_o) begin
                        case (opc)
                            OP_CONT: begin
                                pc    <= pc_inc;
                                state <= FETCH;
                            end
                            OP_JMP: begin
                                pc    <= dir;
                                state <= FETCH;
                            end
                            OP_JT: begin
                                pc    <= x ? dir : pc_inc;
                                state <= FETCH;
                            end
                            OP_JF: begin
                                pc    <= x ? pc_inc : dir;
                                state <= FETCH;
                            end
                            OP_CALL: begin
                                if (full) begin
                                    err   <= 1'b1;
                                    ctl   <= '0;
                                    state <= ERR;
                                end else begin
                                    sp    <= sp + SPW'(1);
                                    pc    <= dir;
                                    state <= FETCH;
                                end
                            end
                            OP_RET: begin
                                if (empty) begin
                                    err   <= 1'b1;
                                    ctl   <= '0;
                                    state <= ERR;
                                end else begin
                                    sp    <= sp - SPW'(1);
                                    pc    <= stk[IXW'(sp - SPW'(1))];
                                    state <= FETCH;
                                end
                            end
                            OP_WAITC: begin
                                // a false condition stays in READY so ir re-executes on the next tick
                                if (x) begin
                                    pc    <= pc_inc;
                                    state <= FETCH;
                                end
                            end
                            OP_HALT: begin
                                halted <= 1'b1;
                                state  <= HALT;
                            end
                            default: state <= FETCH;
                        endcase
                    end
                end
                HALT: state <= HALT;
                ERR:  state <= ERR;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_useq_stack.sv
// Directed bench for useq_stack: single-step vector table plus multi-step program sequences.
module tb_useq_stack;

    localparam int AW  = 5;
    localparam int NC  = 6;
    localparam int OW  = 4;
    localparam int SD  = 2;
    localparam int DIV = 4;
    localparam int SW  = $clog2(NC) + 1;
    localparam int IW  = 3 + SW + AW + OW;

    localparam logic [2:0] CONT  = 3'd0;
    localparam logic [2:0] JMP   = 3'd1;
    localparam logic [2:0] JT    = 3'd2;
    localparam logic [2:0] JF    = 3'd3;
    localparam logic [2:0] CALL  = 3'd4;
    localparam logic [2:0] RET   = 3'd5;
    localparam logic [2:0] WAITC = 3'd6;
    localparam logic [2:0] HLT   = 3'd7;

    logic          ck = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] cond = '0;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_q;
    logic [OW-1:0] ctl;
    logic [AW-1:0] pc_o;
    logic          tick_o;
    logic          halted;
    logic          err;

    logic [IW-1:0] mem [32];

    int n_asrt = 0;
    int n_fail = 0;

    typedef struct {
        logic [IW-1:0] ins;
        logic [NC-1:0] cnd;
        logic [AW-1:0] pc;
        logic [OW-1:0] ctl;
        logic          h;
        logic          e;
    } vec_t;

    vec_t vt [15];

    useq_stack #(.AW(AW), .NC(NC), .OW(OW), .SD(SD), .DIV(DIV)) dut (
        .ck       (ck),
        .rst      (rst),
        .cond     (cond),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .ctl      (ctl),
        .pc_o     (pc_o),
        .tick_o   (tick_o),
        .halted   (halted),
        .err      (err)
    );

    assign rom_q = mem[rom_addr];

    always #5 ck = ~ck;

    function automatic logic [IW-1:0] ins(input logic [2:0] op, input logic [SW-1:0] s,
                                          input logic [AW-1:0] d, input logic [OW-1:0] c);
        return {op, s, d, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_default();
        for (int i = 0; i < 32; i++) mem[i] = ins(CONT, 4'd0, 5'd0, 4'h5);
    endtask

    task automatic do_reset();
        @(negedge ck);
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
    endtask

    // waits for the tick, then returns at the negedge just after the executing edge
    task automatic step();
        int n = 0;
        while (tick_o !== 1'b1 && n < 20) begin
            @(negedge ck);
            n++;
        end
        chk("tick_seen", 32'(tick_o), 32'd1);
        @(negedge ck);
    endtask

    task automatic run_jt(input logic [SW-1:0] s, input logic c0, input logic [AW-1:0] exp);
        fill_default();
        mem[0] = ins(JMP, 4'd0, 5'd3, 4'h1);
        mem[3] = ins(JT, s, 5'd9, 4'h2);
        cond = {5'b0, c0};
        do_reset();
        step();
        chk("jt_pre_pc", 32'(pc_o), 32'd3);
        step();
        chk("jt_pc", 32'(pc_o), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{ins(CONT,  4'd0,  5'd0,  4'h3), 6'b000000, 5'd1,  4'h5, 1'b0, 1'b0};
        vt[1]  = '{ins(JMP,   4'd0,  5'd7,  4'h1), 6'b000000, 5'd7,  4'h5, 1'b0, 1'b0};
        vt[2]  = '{ins(JT,    4'd0,  5'd9,  4'h2), 6'b000001, 5'd9,  4'h5, 1'b0, 1'b0};
        vt[3]  = '{ins(JT,    4'd0,  5'd9,  4'h2), 6'b000000, 5'd1,  4'h5, 1'b0, 1'b0};
        vt[4]  = '{ins(JF,    4'd1,  5'd12, 4'h2), 6'b000000, 5'd12, 4'h5, 1'b0, 1'b0};
        vt[5]  = '{ins(JF,    4'd1,  5'd12, 4'h2), 6'b000010, 5'd1,  4'h5, 1'b0, 1'b0};
        vt[6]  = '{ins(JT,    4'd8,  5'd9,  4'h2), 6'b000001, 5'd1,  4'h5, 1'b0, 1'b0};
        vt[7]  = '{ins(JT,    4'd7,  5'd9,  4'h2), 6'b111111, 5'd1,  4'h5, 1'b0, 1'b0};
        vt[8]  = '{ins(JT,    4'd14, 5'd9,  4'h2), 6'b000000, 5'd9,  4'h5, 1'b0, 1'b0};
        vt[9]  = '{ins(RET,   4'd0,  5'd0,  4'h4), 6'b000000, 5'd0,  4'h0, 1'b0, 1'b1};
        vt[10] = '{ins(HLT,   4'd0,  5'd0,  4'h6), 6'b000000, 5'd0,  4'h6, 1'b1, 1'b0};
        vt[11] = '{ins(WAITC, 4'd2,  5'd0,  4'h9), 6'b000100, 5'd1,  4'h5, 1'b0, 1'b0};
        vt[12] = '{ins(WAITC, 4'd2,  5'd0,  4'h9), 6'b000000, 5'd0,  4'h9, 1'b0, 1'b0};
        vt[13] = '{ins(CALL,  4'd0,  5'd20, 4'h1), 6'b000000, 5'd20, 4'h5, 1'b0, 1'b0};
        vt[14] = '{ins(JT,    4'd5,  5'd3,  4'h2), 6'b100000, 5'd3,  4'h5, 1'b0, 1'b0};

        fill_default();
        @(negedge ck);
        chk("rst_pc",     32'(pc_o),   32'd0);
        chk("rst_ctl",    32'(ctl),    32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err",    32'(err),    32'd0);
        chk("rst_tick",   32'(tick_o), 32'd0);

        for (int i = 0; i < 15; i++) begin
            fill_default();
            mem[0] = vt[i].ins;
            cond = vt[i].cnd;
            do_reset();
            step();
            @(negedge ck);
            chk($sformatf("v%0d_pc", i),     32'(pc_o),   32'(vt[i].pc));
            chk($sformatf("v%0d_ctl", i),    32'(ctl),    32'(vt[i].ctl));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vt[i].h));
            chk($sformatf("v%0d_err", i),    32'(err),    32'(vt[i].e));
        end

        // CONT, CONT, JMP 0 loop; ctl follows each pc change by one cycle
        fill_default();
        mem[0] = ins(CONT, 4'd0, 5'd0, 4'h1);
        mem[1] = ins(CONT, 4'd0, 5'd0, 4'h2);
        mem[2] = ins(JMP,  4'd0, 5'd0, 4'h3);
        cond = '0;
        do_reset();
        @(negedge ck);
        chk("loop_ctl0", 32'(ctl), 32'h1);
        step();
        chk("loop_pc1", 32'(pc_o), 32'd1);
        chk("loop_ctl_old1", 32'(ctl), 32'h1);
        @(negedge ck);
        chk("loop_ctl1", 32'(ctl), 32'h2);
        step();
        chk("loop_pc2", 32'(pc_o), 32'd2);
        @(negedge ck);
        chk("loop_ctl2", 32'(ctl), 32'h3);
        step();
        chk("loop_pc0", 32'(pc_o), 32'd0);
        chk("loop_ctl_old0", 32'(ctl), 32'h3);
        @(negedge ck);
        chk("loop_ctl3", 32'(ctl), 32'h1);

        // pc wraps from the top address to 0
        fill_default();
        mem[0]  = ins(JMP,  4'd0, 5'd31, 4'h3);
        mem[31] = ins(CONT, 4'd0, 5'd0,  4'h2);
        do_reset();
        step();
        chk("wrap_pc31", 32'(pc_o), 32'd31);
        step();
        chk("wrap_pc0", 32'(pc_o), 32'd0);

        run_jt(4'd0, 1'b1, 5'd9);
        run_jt(4'd0, 1'b0, 5'd4);
        run_jt(4'd8, 1'b1, 5'd4);
        run_jt(4'd8, 1'b0, 5'd9);

        // CALL 10 / RET back to 3; a RET at 3 then underflows, so the stack was empty
        fill_default();
        mem[2]  = ins(CALL, 4'd0, 5'd10, 4'h7);
        mem[10] = ins(RET,  4'd0, 5'd0,  4'h8);
        mem[3]  = ins(RET,  4'd0, 5'd0,  4'h9);
        cond = '0;
        do_reset();
        step();
        step();
        chk("call_pc2", 32'(pc_o), 32'd2);
        step();
        chk("call_pc10", 32'(pc_o), 32'd10);
        step();
        chk("ret_pc3", 32'(pc_o), 32'd3);
        chk("ret_err0", 32'(err), 32'd0);
        step();
        chk("ret_empty_err", 32'(err), 32'd1);
        chk("ret_empty_pc", 32'(pc_o), 32'd3);

        // recursive CALL overflows the 2-deep stack on the third call
        fill_default();
        mem[1] = ins(CALL, 4'd0, 5'd1, 4'h7);
        do_reset();
        step();
        chk("rec_pc", 32'(pc_o), 32'd1);
        step();
        chk("rec_err_c1", 32'(err), 32'd0);
        step();
        chk("rec_err_c2", 32'(err), 32'd0);
        @(negedge ck);
        chk("rec_ctl_c2", 32'(ctl), 32'h7);
        step();
        chk("rec_err_c3", 32'(err), 32'd1);
        chk("rec_ctl_c3", 32'(ctl), 32'h0);
        chk("rec_pc_c3", 32'(pc_o), 32'd1);
        step();
        chk("rec_err_hold", 32'(err), 32'd1);
        chk("rec_pc_hold", 32'(pc_o), 32'd1);
        @(negedge ck);
        rst = 1'b1;
        #1;
        chk("rec_rst_err", 32'(err), 32'd0);
        chk("rec_rst_pc", 32'(pc_o), 32'd0);

        // WAITC on cond[2]: a pulse between ticks is ignored
        fill_default();
        mem[0] = ins(CONT,  4'd0, 5'd0, 4'h1);
        mem[1] = ins(WAITC, 4'd2, 5'd0, 4'h4);
        mem[2] = ins(CONT,  4'd0, 5'd0, 4'h8);
        cond = '0;
        do_reset();
        step();
        chk("wait_pc1", 32'(pc_o), 32'd1);
        for (int t = 0; t < 3; t++) begin
            step();
            chk($sformatf("wait_hold%0d", t), 32'(pc_o), 32'd1);
            chk($sformatf("wait_ctl%0d", t), 32'(ctl), 32'h4);
            if (t == 0) begin
                @(negedge ck);
                cond[2] = 1'b1;
                @(negedge ck);
                cond[2] = 1'b0;
            end
        end
        cond[2] = 1'b1;
        step();
        chk("wait_pc2", 32'(pc_o), 32'd2);
        @(negedge ck);
        chk("wait_ctl2", 32'(ctl), 32'h8);

        // HALT, then reset asserted mid-counter
        fill_default();
        mem[0] = ins(JMP, 4'd0, 5'd5, 4'h2);
        mem[5] = ins(HLT, 4'd0, 5'd0, 4'h6);
        cond = '0;
        do_reset();
        step();
        step();
        chk("halt_h", 32'(halted), 32'd1);
        repeat (2) @(negedge ck);
        chk("halt_h_hold", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc_o), 32'd5);
        chk("halt_ctl", 32'(ctl), 32'h6);
        rst = 1'b1;
        #1;
        chk("hrst_pc", 32'(pc_o), 32'd0);
        chk("hrst_addr", 32'(rom_addr), 32'd0);
        chk("hrst_ctl", 32'(ctl), 32'd0);
        chk("hrst_halted", 32'(halted), 32'd0);
        chk("hrst_err", 32'(err), 32'd0);
        chk("hrst_tick", 32'(tick_o), 32'd0);
        @(negedge ck);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
